// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl
// Scan controller for the text generator. It divides the system clock to the pixel
// rate, runs the horizontal/vertical scan counters and produces the VGA sync and
// blanking signals. It also synchronizes the user switches and republishes them
// only at frame wrap, so colour/mode changes never tear mid-frame.
//
// Ports:
//   clk          in   1   system clock, sole clock domain
//   reset        in   1   synchronous, active-high reset
//   sw_in        in   3   raw switches {sw3, sw2, sw1}, asynchronous
//   p_tick       out  1   one-clk pulse per pixel period
//   pixel_x      out  10  horizontal position, 0..H_TOTAL-1
//   pixel_y      out  10  vertical position, 0..V_TOTAL-1
//   video_on     out  1   high inside the visible area
//   hsync        out  1   horizontal sync, active low
//   vsync        out  1   vertical sync, active low
//   frame_start  out  1   one-clk pulse on the last pixel tick of a frame
//   sw_cfg       out  3   synchronized switches, updated only at frame wrap
//
// DIV must be at least 2 so that the prescaler reset value does not look like a tick.
// H_TOTAL and V_TOTAL must not exceed 1024 (10-bit counters).

module vga_scan_ctrl #(
    parameter int unsigned DIV       = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw_in,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic [2:0] sw_cfg
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = $clog2(DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0]       V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0]       HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]       HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]       VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]       VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // State
    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_h_cnt;
    logic [9:0]       r_v_cnt;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_sw_cfg;

    // Combinational helpers
    logic [DIV_W-1:0] w_div_next;
    logic             w_p_tick;
    logic             w_h_last;
    logic             w_v_last;
    logic [9:0]       w_h_next;
    logic [9:0]       w_v_next;
    logic             w_frame_start;
    logic             w_hsync_next;
    logic             w_vsync_next;
    logic             w_video_on_next;

    assign w_p_tick   = (r_div_cnt == DIV_LAST);
    assign w_div_next = w_p_tick ? '0 : r_div_cnt + 1'b1;
    assign w_h_last   = (r_h_cnt == H_LAST);
    assign w_v_last   = (r_v_cnt == V_LAST);

    // Gated by reset so a wrap coinciding with reset never reports a frame.
    assign w_frame_start = w_p_tick & w_h_last & w_v_last & ~reset;

    always_comb begin
        w_h_next = r_h_cnt;
        w_v_next = r_v_cnt;
        if (w_p_tick) begin
            if (w_h_last) begin
                w_h_next = '0;
                w_v_next = w_v_last ? '0 : r_v_cnt + 10'd1;
            end else begin
                w_h_next = r_h_cnt + 10'd1;
            end
        end
    end

    // Sync/blank are decoded from the next counter values and registered, which keeps
    // them on the same edge as pixel_x/pixel_y rather than one pixel late.
    always_comb begin
        w_hsync_next    = !((w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST));
        w_vsync_next    = !((w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST));
        w_video_on_next = (w_h_next < H_VIS) && (w_v_next < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt  <= '0;
            r_h_cnt    <= '0;
            r_v_cnt    <= '0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sw_cfg   <= '0;
        end else begin
            r_div_cnt  <= w_div_next;
            r_h_cnt    <= w_h_next;
            r_v_cnt    <= w_v_next;
            r_hsync    <= w_hsync_next;
            r_vsync    <= w_vsync_next;
            r_video_on <= w_video_on_next;
            r_sync1    <= sw_in;
            r_sync2    <= r_sync1;
            // Config only moves at frame wrap; new value is live from pixel (0,0).
            if (w_frame_start) begin
                r_sw_cfg <= r_sync2;
            end
        end
    end

    assign p_tick      = w_p_tick;
    assign pixel_x     = r_h_cnt;
    assign pixel_y     = r_v_cnt;
    assign video_on    = r_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = w_frame_start;
    assign sw_cfg      = r_sw_cfg;

endmodule
